// File: rtl/mul_issue_ctrl_pkg.sv
// Shared encodings for the multiply issue controller: op select, FSM states
// and the datapath width.
package mul_issue_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 2;

  typedef enum logic [1:0] {
    MULTU   = 2'd0,
    MULTS   = 2'd1,
    MULTUHI = 2'd2,
    MULTSHI = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FIXUP = 3'd3,
    S_DRAIN = 3'd4
  } mul_state_e;

  function automatic logic op_is_signed(input mul_op_e op);
    return (op == MULTS) || (op == MULTSHI);
  endfunction

  function automatic logic op_is_high(input mul_op_e op);
    return (op == MULTUHI) || (op == MULTSHI);
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bundles the execute-stage request/result signals and the multiplier
// operand/product signals seen by the issue controller.
interface mul_issue_ctrl_if #(
  parameter int DATA_W = mul_issue_ctrl_pkg::DATA_W,
  parameter int OP_W   = mul_issue_ctrl_pkg::OP_W
);

  logic                  req;
  logic [OP_W-1:0]       op;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic                  flush;
  logic                  stall;
  logic [DATA_W-1:0]     result;
  logic                  result_valid;
  logic [DATA_W-1:0]     mul_a;
  logic [DATA_W-1:0]     mul_b;
  logic                  mul_start;
  logic [2*DATA_W-1:0]   mul_y;
  logic                  mul_done;

  // The controller is the slave; the CPU plus multiplier form the master side.
  modport slave (
    input  req, op, a, b, flush, mul_y, mul_done,
    output stall, result, result_valid, mul_a, mul_b, mul_start
  );

  modport master (
    output req, op, a, b, flush, mul_y, mul_done,
    input  stall, result, result_valid, mul_a, mul_b, mul_start
  );

endinterface

// File: rtl/mul_issue_ctrl_negate.sv
// Conditional two's-complement negation, used both to turn signed operands
// into magnitudes and to restore the sign of the 64-bit product.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + WIDTH'(1)) : x_i;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller between the execute stage and an unsigned pipelined
// multiplier: magnitude conversion, start/done handshake, sign fix-up, flush drain.
module mul_issue_ctrl #(
  parameter int OP_W   = mul_issue_ctrl_pkg::OP_W,
  parameter int DATA_W = mul_issue_ctrl_pkg::DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  mul_issue_ctrl_if.slave bus
);

  import mul_issue_ctrl_pkg::*;

  mul_state_e          state_q;
  logic [DATA_W-1:0]   mul_a_q;
  logic [DATA_W-1:0]   mul_b_q;
  logic [DATA_W-1:0]   result_q;
  logic [2*DATA_W-1:0] prod_q;
  logic                neg_q;
  logic                high_q;
  logic                mul_start_q;
  logic                result_valid_q;

  mul_op_e             op_d;
  logic                signed_d;
  logic                high_d;
  logic                neg_d;
  logic                accept_d;
  logic                stall_d;
  logic [DATA_W-1:0]   mul_a_d;
  logic [DATA_W-1:0]   mul_b_d;
  logic [2*DATA_W-1:0] prod_d;

  assign op_d     = mul_op_e'(bus.op[OP_W-1:0]);
  assign signed_d = op_is_signed(op_d);
  assign high_d   = op_is_high(op_d);
  assign neg_d    = signed_d & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
  assign accept_d = (state_q == S_IDLE) & bus.req & ~bus.flush;

  twos_negate #(.WIDTH(DATA_W)) u_neg_a (
    .x_i   (bus.a),
    .neg_i (signed_d & bus.a[DATA_W-1]),
    .y_o   (mul_a_d)
  );

  twos_negate #(.WIDTH(DATA_W)) u_neg_b (
    .x_i   (bus.b),
    .neg_i (signed_d & bus.b[DATA_W-1]),
    .y_o   (mul_b_d)
  );

  twos_negate #(.WIDTH(2*DATA_W)) u_neg_p (
    .x_i   (bus.mul_y),
    .neg_i (neg_q),
    .y_o   (prod_d)
  );

  // A live request arriving in IDLE or DRAIN stalls at once, so the CPU holds it until accepted.
  assign stall_d = reset & (
                     (bus.req & ~bus.flush & ((state_q == S_IDLE) | (state_q == S_DRAIN))) |
                     (state_q == S_ISSUE) |
                     (state_q == S_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      result_q       <= '0;
      prod_q         <= '0;
      neg_q          <= 1'b0;
      high_q         <= 1'b0;
      mul_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      mul_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            neg_q       <= neg_d;
            high_q      <= high_d;
            mul_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= bus.flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          // A done that coincides with a flush has already drained the multiplier.
          if (bus.mul_done) begin
            if (bus.flush) begin
              state_q <= S_IDLE;
            end else begin
              prod_q  <= prod_d;
              state_q <= S_FIXUP;
            end
          end else if (bus.flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_FIXUP: begin
          result_q       <= high_q ? prod_q[2*DATA_W-1:DATA_W] : prod_q[DATA_W-1:0];
          result_valid_q <= 1'b1;
          state_q        <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus.mul_done) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall        = stall_d;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.mul_start    = mul_start_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomized scoreboard bench for mul_issue_ctrl with a behavioural
// multiplier and an arithmetic reference model.
module tb_mul_issue_ctrl;

  import mul_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int fixedLatency = 0;
  bit strayDone = 1'b0;

  logic [31:0] resQ[$];
  logic [63:0] opQ[$];

  mul_issue_ctrl_if bus();

  mul_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Architectural result: full-precision product of the operands read as the op says, then word select.
  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint full;
    logic [63:0] bits;
    bit isSigned;
    isSigned = (op == MULTS) || (op == MULTSHI);
    sa = isSigned ? longint'($signed(a)) : longint'({32'b0, a});
    sb = isSigned ? longint'($signed(b)) : longint'({32'b0, b});
    full = sa * sb;
    bits = 64'(full);
    return ((op == MULTUHI) || (op == MULTSHI)) ? bits[63:32] : bits[31:0];
  endfunction

  function automatic logic [31:0] magOf(input logic [1:0] op, input logic [31:0] x);
    longint v;
    logic [63:0] bits;
    v = ((op == MULTS) || (op == MULTSHI)) ? longint'($signed(x)) : longint'({32'b0, x});
    if (v < 0) v = -v;
    bits = 64'(v);
    return bits[31:0];
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'(0) - 32'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Unsigned multiplier model: captures operands on start, checks they stay put, pulses done later.
  initial begin : mulModel
    logic [63:0] prod;
    logic [63:0] expOps;
    logic [31:0] heldA;
    logic [31:0] heldB;
    int count;
    bit busy;
    count = 0;
    busy = 1'b0;
    prod = '0;
    heldA = '0;
    heldB = '0;
    bus.mul_done = 1'b0;
    bus.mul_y = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mul_done = 1'b0;
      if (!reset) begin
        busy = 1'b0;
        count = 0;
      end else begin
        if (strayDone) begin
          bus.mul_done = 1'b1;
          bus.mul_y = {$urandom, $urandom};
        end
        if (busy) begin
          checkOutput("mul_a_stable", 64'(bus.mul_a), 64'(heldA));
          checkOutput("mul_b_stable", 64'(bus.mul_b), 64'(heldB));
          count--;
          if (count == 0) begin
            busy = 1'b0;
            bus.mul_done = 1'b1;
            bus.mul_y = prod;
          end
        end
        if (bus.mul_start === 1'b1) begin
          startCount++;
          checkOutput("start_while_busy", 64'(busy), 64'(0));
          if (opQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_mul_start actual=1 required=0");
          end else begin
            expOps = opQ.pop_front();
            checkOutput("mul_a", 64'(bus.mul_a), 64'(expOps[63:32]));
            checkOutput("mul_b", 64'(bus.mul_b), 64'(expOps[31:0]));
          end
          heldA = bus.mul_a;
          heldB = bus.mul_b;
          prod = {32'b0, heldA} * {32'b0, heldB};
          busy = 1'b1;
          count = (fixedLatency > 0) ? fixedLatency : int'($urandom_range(2, 8));
        end
      end
    end
  end

  initial begin : monitor
    logic [31:0] expected;
    forever begin
      @(posedge clk);
      #1;
      if (bus.result_valid === 1'b1) begin
        if (resQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result_valid actual=%h required=none", bus.result);
        end else begin
          expected = resQ.pop_front();
          checkOutput("result", 64'(bus.result), 64'(expected));
        end
      end
    end
  end

  // Presents one request and holds it while stalled; flushNext cancels it one cycle later.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit flushNext);
    bit stallSeen;
    bit released;
    released = 1'b0;
    @(negedge clk);
    bus.req = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.flush = 1'b0;
    opQ.push_back({magOf(op, a), magOf(op, b)});
    if (flushNext) begin
      @(negedge clk);
      bus.req = 1'b0;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
    end else begin
      resQ.push_back(refResult(op, a, b));
      for (int cyc = 0; cyc < 64 && !released; cyc++) begin
        #1;
        stallSeen = bus.stall;
        if (cyc == 0) checkOutput("stall_on_req", 64'(stallSeen), 64'(1));
        @(negedge clk);
        if (!stallSeen) released = 1'b1;
      end
      bus.req = 1'b0;
      checks++;
      if (!released) begin
        errors++;
        $display("[TB] FAIL stall_release actual=timeout required=release");
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    int s0;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bus.req = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_stall", 64'(bus.stall), 64'(0));
    checkOutput("reset_result_valid", 64'(bus.result_valid), 64'(0));
    checkOutput("reset_mul_start", 64'(bus.mul_start), 64'(0));
    checkOutput("reset_result", 64'(bus.result), 64'(0));
    checkOutput("reset_mul_a", 64'(bus.mul_a), 64'(0));
    checkOutput("reset_mul_b", 64'(bus.mul_b), 64'(0));
    reset = 1'b1;

    fixedLatency = 5;
    s0 = startCount;
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    #1;
    checkOutput("stall_after_result", 64'(bus.stall), 64'(0));
    applyStimulus(MULTUHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(MULTS, 32'hFFFF_FFF9, 32'h0000_0006, 1'b0);
    applyStimulus(MULTSHI, 32'hFFFF_FFF9, 32'h0000_0006, 1'b0);
    applyStimulus(MULTS, 32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus(MULTSHI, 32'h8000_0000, 32'h8000_0000, 1'b0);
    checkOutput("start_count", 64'(startCount), 64'(s0 + 6));
    repeat (3) @(negedge clk);
    checkOutput("result_hold", 64'(bus.result), 64'(32'h4000_0000));

    applyStimulus(MULTS, 32'h1234_5678, 32'hFFFF_0000, 1'b1);
    applyStimulus(MULTU, 32'hDEAD_BEEF, 32'h0001_0001, 1'b0);

    s0 = startCount;
    @(negedge clk);
    bus.req = 1'b1;
    bus.flush = 1'b1;
    bus.op = MULTU;
    bus.a = 32'h0000_0003;
    bus.b = 32'h0000_0004;
    #1;
    checkOutput("stall_flushed_req", 64'(bus.stall), 64'(0));
    @(negedge clk);
    bus.req = 1'b0;
    bus.flush = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("no_start_on_flushed_req", 64'(startCount), 64'(s0));

    fixedLatency = 0;
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = pickOperand();
      rb = pickOperand();
      applyStimulus(rop, ra, rb, ($urandom_range(0, 4) == 0));
    end
    repeat (10) @(negedge clk);

    fixedLatency = 6;
    @(negedge clk);
    bus.req = 1'b1;
    bus.op = MULTSHI;
    bus.a = 32'hFFFF_FF00;
    bus.b = 32'h0000_1234;
    opQ.push_back({magOf(MULTSHI, 32'hFFFF_FF00), magOf(MULTSHI, 32'h0000_1234)});
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    s0 = startCount;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_stall", 64'(bus.stall), 64'(0));
    checkOutput("async_reset_result_valid", 64'(bus.result_valid), 64'(0));
    checkOutput("async_reset_mul_start", 64'(bus.mul_start), 64'(0));
    checkOutput("async_reset_result", 64'(bus.result), 64'(0));
    checkOutput("async_reset_mul_a", 64'(bus.mul_a), 64'(0));
    checkOutput("async_reset_mul_b", 64'(bus.mul_b), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    strayDone = 1'b1;
    @(negedge clk);
    strayDone = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("no_start_after_reset", 64'(startCount), 64'(s0));

    checkOutput("result_queue_empty", 64'(resQ.size()), 64'(0));
    checkOutput("operand_queue_empty", 64'(opQ.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
